// File: rtl/id_ex_reg.sv
// ID->EX pipeline register: captures the decoded ID bundle for EX, inserts bubbles
// on stall, clears on flush, and counts inserted bubbles (saturating).
module id_ex_reg #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned EXC_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      req_pc,
    input  logic [31:0]      d_instr,
    input  logic [31:0]      d_pc,
    input  logic [31:0]      d_imm32,
    input  logic [31:0]      d_rs_data,
    input  logic [31:0]      d_rt_data,
    input  logic [EXC_W-1:0] d_exc_code,
    input  logic             d_bd,
    output logic [31:0]      e_instr,
    output logic [31:0]      e_pc,
    output logic [31:0]      e_imm32,
    output logic [31:0]      e_rs_data,
    output logic [31:0]      e_rt_data,
    output logic [EXC_W-1:0] e_exc_code,
    output logic             e_bd,
    output logic             e_valid,
    output logic [31:0]      bubble_cnt
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_instr    <= '0;
            e_pc       <= PC_RESET;
            e_imm32    <= '0;
            e_rs_data  <= '0;
            e_rt_data  <= '0;
            e_exc_code <= '0;
            e_bd       <= 1'b0;
            e_valid    <= 1'b0;
            bubble_cnt <= '0;
        end else if (flush || stall) begin
            // Bubble: only PC/BD survive a stall so CP0 can build EPC/BD on it
            e_instr    <= '0;
            e_pc       <= flush ? req_pc : d_pc;
            e_imm32    <= '0;
            e_rs_data  <= '0;
            e_rt_data  <= '0;
            e_exc_code <= '0;
            e_bd       <= flush ? 1'b0 : d_bd;
            e_valid    <= 1'b0;
            if (bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 32'd1;
        end else begin
            e_instr    <= d_instr;
            e_pc       <= d_pc;
            e_imm32    <= d_imm32;
            e_rs_data  <= d_rs_data;
            e_rt_data  <= d_rt_data;
            e_exc_code <= d_exc_code;
            e_bd       <= d_bd;
            e_valid    <= 1'b1;
        end
    end

endmodule
